client_rx_regctl: RTL and testbench

- Receive-side controller that turns UDP payloads from the Ethernet client port into register writes for downstream config registers (PWM duty, LED and misc control).
- Payload is a sequence of (address, data) octet pairs.
- Pairs are staged during the packet and committed only after the CRC-good indication, one write per cycle, in arrival order.
- Packets without a CRC-good indication never reach the register bank.

---
 rtl/client_rx_pkg.sv | 27 ++
 rtl/client_rx_stage.sv | 38 +++
 rtl/client_rx_regctl.sv | 186 ++++++++++++++++++
 tb/tb_client_rx_regctl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/client_rx_pkg.sv
// Shared types for the client receive register controller.
//   state_t : controller FSM encoding
//   pair_t  : one staged (address, data) register write
//   CNT_W   : width of the packet good/drop counters
//   ptr_w() : stage pointer width, one bit wider than the index so a
//             pointer can hold the value max_pairs (stage full)
package client_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_CRC = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pair_t;

    function automatic int ptr_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/client_rx_stage.sv
// Staging buffer for (address, data) pairs of one packet.
//   clk     : clock
//   wr_req  : a complete pair is presented this cycle
//   wp      : write pointer (count of pairs already stored)
//   wr_pair : pair to store
//   rd_idx  : asynchronous read index
//   rd_pair : pair at rd_idx
//   wr_ok   : pair actually stored (request while not full)
//   full    : wp has reached max_pairs
module client_rx_stage
    import client_rx_pkg::*;
#(
    parameter int max_pairs = 8,
    parameter int PW        = ptr_w(max_pairs)
) (
    input  logic          clk,
    input  logic          wr_req,
    input  logic [PW-1:0] wp,
    input  pair_t         wr_pair,
    input  logic [PW-2:0] rd_idx,
    output pair_t         rd_pair,
    output logic          wr_ok,
    output logic          full
);

    pair_t mem [max_pairs];

    assign full    = (wp == PW'(max_pairs));
    assign wr_ok   = wr_req && !full;
    assign rd_pair = mem[rd_idx];

    // Contents need no reset: only entries written in the current packet
    // are ever read back.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp[PW-2:0]] <= wr_pair;
    end

endmodule

// File: rtl/client_rx_regctl.sv
// Receive-side controller: stages (addr, data) octet pairs from the client
// payload stream and replays them as register writes only after CRC-good.
//   clk, rst          : clock, synchronous active-high reset
//   ready             : link ready; low aborts to IDLE
//   strobe, data_in   : payload octet stream
//   crc               : one-cycle CRC-good pulse for the last packet
//   reg_addr/data/we  : register write port, one write per cycle
//   busy              : FSM not in IDLE
//   overflow          : sticky, a packet exceeded max_pairs pairs
//   pkt_good/pkt_drop : saturating committed/discarded packet counts
module client_rx_regctl
    import client_rx_pkg::*;
#(
    parameter int max_pairs  = 8,
    parameter int crc_window = 4,
    parameter int jumbo_dw   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic             strobe,
    input  logic             crc,
    input  logic [7:0]       data_in,
    output logic [7:0]       reg_addr,
    output logic [7:0]       reg_data,
    output logic             reg_we,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] pkt_good,
    output logic [CNT_W-1:0] pkt_drop
);

    localparam int         PW     = ptr_w(max_pairs);
    localparam logic [3:0] T_LAST = 4'(crc_window - 1);

    state_t              state, state_nxt;
    logic [PW-1:0]       wp, rp;
    logic [jumbo_dw-1:0] oct_cnt;
    logic [7:0]          pend_addr;
    logic [3:0]          timer;
    logic                foreign;   // packet seen during COMMIT, not yet ended

    logic start_pkt, rx_octet, stage_req, good_inc, drop_inc, clr_ptrs;
    logic timer_inc, issue, foreign_set, foreign_clr, expired;
    logic stg_wr_ok, stg_full;
    pair_t rd_pair;

    client_rx_stage #(.max_pairs(max_pairs), .PW(PW)) u_stage (
        .clk     (clk),
        .wr_req  (stage_req),
        .wp      (wp),
        .wr_pair ('{addr: pend_addr, data: data_in}),
        .rd_idx  (rp[PW-2:0]),
        .rd_pair (rd_pair),
        .wr_ok   (stg_wr_ok),
        .full    (stg_full)
    );

    assign busy    = (state != IDLE);
    assign expired = (timer == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_pkt   = 1'b0;
        rx_octet    = 1'b0;
        stage_req   = 1'b0;
        good_inc    = 1'b0;
        drop_inc    = 1'b0;
        clr_ptrs    = 1'b0;
        timer_inc   = 1'b0;
        issue       = 1'b0;
        foreign_set = 1'b0;
        foreign_clr = 1'b0;
        if (!ready) begin
            state_nxt   = IDLE;
            clr_ptrs    = 1'b1;
            foreign_clr = 1'b1;
            drop_inc    = (state == RECV) || (state == WAIT_CRC);
        end else begin
            // A packet that overlapped COMMIT is counted as dropped when it ends.
            if (foreign && !strobe) begin
                foreign_clr = 1'b1;
                drop_inc    = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (strobe && !foreign) begin
                        start_pkt = 1'b1;
                        state_nxt = RECV;
                    end
                end
                RECV: begin
                    if (strobe) begin
                        rx_octet  = 1'b1;
                        stage_req = oct_cnt[0];
                    end else if (crc) begin
                        // crc in the falling cycle is timer cycle 0
                        good_inc  = 1'b1;
                        state_nxt = (wp != '0) ? COMMIT : IDLE;
                    end else begin
                        state_nxt = WAIT_CRC;
                    end
                end
                WAIT_CRC: begin
                    if (crc && !expired) begin
                        good_inc  = 1'b1;
                        state_nxt = (wp != '0) ? COMMIT : IDLE;
                    end else if (strobe) begin
                        drop_inc  = 1'b1;
                        clr_ptrs  = 1'b1;
                        start_pkt = 1'b1;
                        state_nxt = RECV;
                    end else if (expired) begin
                        drop_inc  = 1'b1;
                        clr_ptrs  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                COMMIT: begin
                    issue       = 1'b1;
                    foreign_set = strobe;
                    if (rp == PW'(wp - 1'b1)) begin
                        clr_ptrs  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            oct_cnt   <= '0;
            pend_addr <= '0;
            timer     <= '0;
            foreign   <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            reg_we    <= 1'b0;
            overflow  <= 1'b0;
            pkt_good  <= '0;
            pkt_drop  <= '0;
        end else begin
            if (start_pkt) begin
                pend_addr <= data_in;
                oct_cnt   <= jumbo_dw'(1);
            end else if (rx_octet) begin
                if (!oct_cnt[0]) pend_addr <= data_in;
                // saturate so a long packet never wraps back to index 0
                if (!(&oct_cnt)) oct_cnt <= oct_cnt + 1'b1;
            end

            if (clr_ptrs)       wp <= '0;
            else if (stg_wr_ok) wp <= wp + 1'b1;

            if (clr_ptrs)   rp <= '0;
            else if (issue) rp <= rp + 1'b1;

            reg_we <= issue;
            if (issue) begin
                reg_addr <= rd_pair.addr;
                reg_data <= rd_pair.data;
            end

            if (stage_req && stg_full) overflow <= 1'b1;
            if (good_inc && pkt_good != '1) pkt_good <= pkt_good + 1'b1;
            if (drop_inc && pkt_drop != '1) pkt_drop <= pkt_drop + 1'b1;

            if (foreign_set)      foreign <= 1'b1;
            else if (foreign_clr) foreign <= 1'b0;

            timer <= timer_inc ? timer + 1'b1 : 4'd0;
        end
    end

endmodule

// File: tb/tb_client_rx_regctl.sv
module tb_client_rx_regctl;

    logic       clk = 1'b0;
    logic       rst, ready, strobe, crc;
    logic [7:0] data_in;
    logic [7:0] reg_addr, reg_data;
    logic       reg_we, busy, overflow;
    logic [7:0] pkt_good, pkt_drop;

    int errors = 0;
    int checks = 0;

    logic [7:0]  pkt [$];
    logic [15:0] wlog [$];

    client_rx_regctl #(.max_pairs(8), .crc_window(4), .jumbo_dw(14)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .strobe   (strobe),
        .crc      (crc),
        .data_in  (data_in),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .reg_we   (reg_we),
        .busy     (busy),
        .overflow (overflow),
        .pkt_good (pkt_good),
        .pkt_drop (pkt_drop)
    );

    always #5 clk = ~clk;

    // Record every write the DUT issues.
    always @(negedge clk) if (reg_we === 1'b1) wlog.push_back({reg_addr, reg_data});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b1; strobe = 1'b0; crc = 1'b0; data_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic send();
        for (int i = 0; i < pkt.size(); i++) begin
            strobe = 1'b1; data_in = pkt[i];
            tick();
        end
        strobe = 1'b0; data_in = 8'h00;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy && !reg_we) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (reg_we !== 1'b0)   begin errors++; $display("FAIL reset_we got=%b exp=0", reg_we); end
        checks++; if (reg_addr !== 8'h0 || reg_data !== 8'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=00/00", reg_addr, reg_data); end
        checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b ovf=%b exp 0/0", busy, overflow); end
        checks++; if (pkt_good !== 8'd0 || pkt_drop !== 8'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", pkt_good, pkt_drop); end
    endtask

    task automatic test_basic();
        do_reset();
        pkt = '{8'h01, 8'hAA, 8'h02, 8'h55};
        send();
        tick();                       // strobe-fall cycle, no crc
        crc = 1'b1; tick(); crc = 1'b0;
        checks++; if (reg_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_k got we=%b busy=%b exp we=0 busy=1", reg_we, busy); end
        checks++; if (pkt_good !== 8'd1) begin errors++; $display("FAIL basic_good got=%0d exp=1", pkt_good); end
        tick();
        checks++; if ({reg_we, reg_addr, reg_data} !== {1'b1, 8'h01, 8'hAA}) begin errors++; $display("FAIL basic_w0 got we=%b %h/%h exp 1 01/aa", reg_we, reg_addr, reg_data); end
        tick();
        checks++; if ({reg_we, reg_addr, reg_data} !== {1'b1, 8'h02, 8'h55}) begin errors++; $display("FAIL basic_w1 got we=%b %h/%h exp 1 02/55", reg_we, reg_addr, reg_data); end
        tick();
        checks++; if ({reg_we, busy, reg_addr, reg_data} !== {1'b0, 1'b0, 8'h02, 8'h55}) begin errors++; $display("FAIL basic_end got we=%b busy=%b %h/%h exp 0 0 02/55", reg_we, busy, reg_addr, reg_data); end
        checks++; if (pkt_drop !== 8'd0 || wlog.size() != 2) begin errors++; $display("FAIL basic_drop got drop=%0d writes=%0d exp 0/2", pkt_drop, wlog.size()); end
    endtask

    task automatic test_no_crc();
        do_reset();
        pkt = '{8'h01, 8'hAA, 8'h02, 8'h55};
        send();
        tick(); tick(); tick(); tick();
        checks++; if (busy !== 1'b1 || pkt_drop !== 8'd0) begin errors++; $display("FAIL nocrc_wait got busy=%b drop=%0d exp 1/0", busy, pkt_drop); end
        tick();
        checks++; if (busy !== 1'b0 || pkt_drop !== 8'd1) begin errors++; $display("FAIL nocrc_timeout got busy=%b drop=%0d exp 0/1", busy, pkt_drop); end
        tick(); tick();
        checks++; if (wlog.size() != 0 || pkt_good !== 8'd0) begin errors++; $display("FAIL nocrc_writes got writes=%0d good=%0d exp 0/0", wlog.size(), pkt_good); end
    endtask

    task automatic test_overflow();
        bit ok;
        bit bad;
        do_reset();
        pkt.delete();
        for (int i = 0; i < 10; i++) begin
            pkt.push_back(8'(i));
            pkt.push_back(8'(8'h80 + i));
        end
        send();
        crc = 1'b1; tick(); crc = 1'b0;   // crc in the strobe-fall cycle
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy=%b exp idle", busy); end
        checks++; if (wlog.size() != 8 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_count got writes=%0d ovf=%b exp 8/1", wlog.size(), overflow); end
        bad = 1'b0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {8'(i), 8'(8'h80 + i)}) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL ovf_order got first=%h last=%h exp 0080..0787", wlog[0], wlog[wlog.size()-1]); end
    endtask

    task automatic test_odd();
        bit ok;
        do_reset();
        pkt = '{8'h03, 8'h7F, 8'h04};
        send();
        tick();
        crc = 1'b1; tick(); crc = 1'b0;
        wait_idle(ok);
        checks++; if (!ok || wlog.size() != 1) begin errors++; $display("FAIL odd_count got ok=%b writes=%0d exp 1/1", ok, wlog.size()); end
        else begin
            checks++; if (wlog[0] !== 16'h037F) begin errors++; $display("FAIL odd_pair got=%h exp=037f", wlog[0]); end
        end
        checks++; if (pkt_good !== 8'd1) begin errors++; $display("FAIL odd_good got=%0d exp=1", pkt_good); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [4] = '{16'h10A0, 16'h11A1, 16'h12A2, 16'h13A3};
        do_reset();
        pkt = '{8'h10, 8'hA0, 8'h11, 8'hA1, 8'h12, 8'hA2, 8'h13, 8'hA3};
        send();
        crc = 1'b1; tick(); crc = 1'b0;   // into COMMIT
        strobe = 1'b1; data_in = 8'h77;   // second packet starts mid-commit
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({reg_we, reg_addr, reg_data} !== {1'b1, exp_w[i]}) begin errors++; $display("FAIL b2b_w%0d got we=%b %h/%h exp 1 %h", i, reg_we, reg_addr, reg_data, exp_w[i]); end
        end
        tick();                            // strobe still high: stay IDLE
        checks++; if (reg_we !== 1'b0 || busy !== 1'b0 || pkt_drop !== 8'd0) begin errors++; $display("FAIL b2b_hold got we=%b busy=%b drop=%0d exp 0 0 0", reg_we, busy, pkt_drop); end
        strobe = 1'b0; data_in = 8'h00;
        tick();
        checks++; if (pkt_drop !== 8'd1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drop got drop=%0d busy=%b exp 1/0", pkt_drop, busy); end
        crc = 1'b1; tick(); crc = 1'b0;   // stray crc in IDLE is ignored
        tick(); tick();
        checks++; if (wlog.size() != 4 || pkt_good !== 8'd1) begin errors++; $display("FAIL b2b_total got writes=%0d good=%0d exp 4/1", wlog.size(), pkt_good); end
    endtask

    task automatic test_reset_mid_commit();
        bit ok;
        do_reset();
        pkt = '{8'h21, 8'hB1, 8'h22, 8'hB2, 8'h23, 8'hB3};
        send();
        crc = 1'b1; tick(); crc = 1'b0;
        tick();
        checks++; if ({reg_we, reg_addr, reg_data} !== {1'b1, 8'h21, 8'hB1}) begin errors++; $display("FAIL rstm_w0 got we=%b %h/%h exp 1 21/b1", reg_we, reg_addr, reg_data); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({reg_we, reg_addr, reg_data, busy, overflow, pkt_good, pkt_drop} !== '0) begin errors++; $display("FAIL rstm_zero got we=%b %h/%h busy=%b good=%0d drop=%0d exp all 0", reg_we, reg_addr, reg_data, busy, pkt_good, pkt_drop); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (wlog.size() != 1) begin errors++; $display("FAIL rstm_nowrite got writes=%0d exp 1", wlog.size()); end
        pkt = '{8'h01, 8'hAA, 8'h02, 8'h55};
        send();
        tick();
        crc = 1'b1; tick(); crc = 1'b0;
        wait_idle(ok);
        checks++; if (!ok || wlog.size() != 3) begin errors++; $display("FAIL rstm_next got ok=%b writes=%0d exp 1/3", ok, wlog.size()); end
        else begin
            checks++; if (wlog[1] !== 16'h01AA || wlog[2] !== 16'h0255) begin errors++; $display("FAIL rstm_pairs got %h %h exp 01aa 0255", wlog[1], wlog[2]); end
        end
        checks++; if (pkt_good !== 8'd1) begin errors++; $display("FAIL rstm_good got=%0d exp=1", pkt_good); end
    endtask

    task automatic test_ready_low();
        do_reset();
        strobe = 1'b1; data_in = 8'h05; tick();
        data_in = 8'h06; tick();
        ready = 1'b0; data_in = 8'h07; tick();
        checks++; if (busy !== 1'b0 || pkt_drop !== 8'd1) begin errors++; $display("FAIL ready_abort got busy=%b drop=%0d exp 0/1", busy, pkt_drop); end
        ready = 1'b1; strobe = 1'b0; data_in = 8'h00;
        tick(); tick();
        crc = 1'b1; tick(); crc = 1'b0;
        tick(); tick();
        checks++; if (wlog.size() != 0 || pkt_good !== 8'd0) begin errors++; $display("FAIL ready_nowrite got writes=%0d good=%0d exp 0/0", wlog.size(), pkt_good); end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; strobe = 1'b0; crc = 1'b0; data_in = 8'h00;
        test_reset();
        test_basic();
        test_no_crc();
        test_overflow();
        test_odd();
        test_back_to_back();
        test_reset_mid_commit();
        test_ready_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
